// File: rtl/lamp_pkg.sv
// rtl/lamp_pkg.sv - lamp light codes, pacing FSM states and dwell helper shared by the lamp blocks
package lamp_pkg;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COUNT,
        ST_STEP,
        ST_FAULT
    } state_t;

    // Dwell as it lands in a cw-bit counter; a zero dwell would never step, so it becomes 1.
    function automatic int clamp_ticks(input int ticks, input int cw);
        int t;
        t = (cw >= 31) ? ticks : (ticks & ((1 << cw) - 1));
        return (t == 0) ? 1 : t;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk into one-cycle ticks every PRESCALE cycles while run is high
module tick_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/lamp_step_timer.sv
// rtl/lamp_step_timer.sv - per-colour dwell timer that paces the traffic lamp with a one-cycle step
module lamp_step_timer
    import lamp_pkg::*;
#(
    parameter int PRESCALE      = 1000,
    parameter int CW            = 8,
    parameter int RED_TICKS     = 30,
    parameter int YEL_TICKS     = 5,
    parameter int GRN_TICKS     = 25,
    parameter int PED_MIN_TICKS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [2:0]    light,
    input  logic          ped_req,
    output logic          step,
    output logic          ped_ack,
    output logic [CW-1:0] remaining,
    output logic          fault
);

    localparam logic [CW-1:0] RED_D   = CW'(clamp_ticks(RED_TICKS, CW));
    localparam logic [CW-1:0] YEL_D   = CW'(clamp_ticks(YEL_TICKS, CW));
    localparam logic [CW-1:0] GRN_D   = CW'(clamp_ticks(GRN_TICKS, CW));
    localparam logic [CW-1:0] PED_D   = CW'(clamp_ticks(PED_MIN_TICKS, CW));
    localparam logic [CW-1:0] PED_CAP = (PED_D < GRN_D) ? PED_D : GRN_D;

    state_t        state, state_nx;
    logic [CW-1:0] rem_nx;
    logic          ped_latch;
    logic          grn_phase, grn_nx;
    logic          ack_nx;
    logic          ped_pending;
    logic          pre_run;
    logic          tick;

    // A request arriving this very cycle already counts as pending.
    assign ped_pending = ped_latch | ped_req;
    assign pre_run     = en && (state == ST_COUNT);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!pre_run),
        .run  (pre_run),
        .tick (tick)
    );

    always_comb begin
        state_nx = state;
        rem_nx   = remaining;
        grn_nx   = grn_phase;
        ack_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                if (!en) begin
                    state_nx = ST_IDLE;
                end else begin
                    grn_nx   = 1'b0;
                    state_nx = ST_COUNT;
                    case (light)
                        LIGHT_RED: begin
                            rem_nx = RED_D;
                            ack_nx = ped_latch;
                        end
                        LIGHT_YEL: rem_nx = YEL_D;
                        LIGHT_GRN: begin
                            rem_nx = ped_pending ? PED_CAP : GRN_D;
                            grn_nx = 1'b1;
                        end
                        default: begin
                            rem_nx   = '0;
                            state_nx = ST_FAULT;
                        end
                    endcase
                end
            end
            ST_COUNT: begin
                if (!en) begin
                    state_nx = ST_IDLE;
                end else if (grn_phase && ped_pending && (remaining > PED_D)) begin
                    // Shortening green wins over a tick landing in the same cycle.
                    rem_nx = PED_D;
                end else if (tick) begin
                    rem_nx = remaining - CW'(1);
                    if (remaining == CW'(1)) state_nx = ST_STEP;
                end
            end
            ST_STEP: begin
                state_nx = en ? ST_LOAD : ST_IDLE;
            end
            ST_FAULT: begin
                rem_nx = '0;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            ped_latch <= 1'b0;
            grn_phase <= 1'b0;
            step      <= 1'b0;
            ped_ack   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= rem_nx;
            ped_latch <= ped_req | (ped_latch & ~ack_nx);
            grn_phase <= grn_nx;
            step      <= (state_nx == ST_STEP);
            ped_ack   <= ack_nx;
            fault     <= (state_nx == ST_FAULT);
        end
    end

endmodule
